ctrl_pipe: RTL
==============

// Module: ctrl_pipe
// PURPOSE
// Pipelined control for the 5-stage MIPS core. Decodes the D-stage instruction and
// carries its control bundle through E/M/W registers. Computes Tuse/Tnew hazard
// stalls and forwarding selects, replacing per-stage decoders plus separate hazard logic.
// Sits between the IF/D register and the datapath stage muxes.
// PARAMETERS
// REG_AW    5   register address width; register 0 is hard-wired zero
// LINK_REG  31  jal destination register
// EXT_ISA   0   1: also decode addiu (op 001001: sign-ext, ALU add, rt dest)
// PORTS
// clk        in   1       rising-edge clock
// reset_n    in   1       asynchronous active-low reset
// instr_d    in   32      instruction held in IF/D register
// stall      out  1       1: hold PC and IF/D, insert bubble into E
// npc_sel_d  out  2       00 pc+4, 01 beq (taken if cmp), 10 j/jal, 11 jr
// ext_op_d   out  2       00 zero, 01 sign, 10 lui (imm<<16)
// fwd_rs_d   out  2       D cmp/jr rs: 0 regfile, 1 from E (pc+8), 2 from M
// fwd_rt_d   out  2       as fwd_rs_d for beq rt
// alu_src_e  out  1       1: ALU B = extended imm
// alu_ctr_e  out  2       00 add, 01 sub, 10 or
// fwd_rs_e   out  2       E ALU A: 0 pipe value, 1 from M, 2 from W
// fwd_rt_e   out  2       E ALU B / store data: same encoding
// mem_we_m   out  1       data-memory write enable
// fwd_rt_m   out  1       M store data: 1 from W
// reg_we_w   out  1       register-file write enable
// mem2reg_w  out  2       00 ALU, 01 mem, 10 pc+8
// a3_w       out  REG_AW  write address (0 when reg_we_w=0)
// BEHAVIOUR
// - Decode set: addu, subu, ori, lw, sw, beq, lui, j, jal, jr (+addiu if EXT_ISA).
//   addu/subu: rd dest; ori/lw/lui(/addiu): rt dest; jal: LINK_REG. Unknown = NOP.
// - Tuse: beq rs/rt, jr rs = 0; ALU/lw/sw rs, addu/subu rt = 1; sw rt = 2.
// - Tnew on E entry: lw 2; addu/subu/ori/lui(/addiu) 1; jal 0; others no write.
//   M Tnew = max(E Tnew-1,0); W Tnew = 0.
// - E/M/W registers: bundle {alu_src, alu_ctr, mem_we, reg_we, mem2reg, a3, tnew,
//   rs, rt}. All three update every cycle; dest 0 forces reg_we=0 at decode.
// - stall (combinational): any used D source s != 0 equal to a3 of E or M with
//   reg_we=1 and stage Tnew > Tuse(s). On stall E loads all-zero bubble; M, W advance.
// - Forwarding: source != 0 matches a3 of stage with reg_we and stage Tnew == 0.
//   Nearest stage wins (E over M for D; M over W for E). W->D is covered by
//   regfile write-through and is never selected here.
// - fwd_* valid only when the stage consumes that source, else 0.
// - reset_n low: E/M/W = NOP immediately (async). All registered outputs 0.
//   stall = 0 while in reset. D-stage outputs follow instr_d combinationally.
// - Reset mid-stall: bubble state discarded; first cycle after release, stall = 0
//   unless instr_d conflicts with nothing (pipe empty) -> always 0.
// - Delay slot architectural: no flush; beq/j/jal/jr never bubble the next instr.
// TESTING
// - lw $1,0($0); addu $2,$1,$1 -> stall=1 one cycle; then fwd_rs_e=fwd_rt_e=2.
// - lw $1; beq $1,$0 -> stall=1 two cycles; third cycle fwd_rs_d=0, npc_sel_d=01.
// - addu $3,$1,$2; beq $3,$3 -> one stall; then fwd_rs_d=fwd_rt_d=2.
// - addu $3; sw $3,0($0) -> no stall; sw in E: fwd_rt_e=1; jal; jr $31 -> fwd_rs_d=1.
// - ori $0,$0,5; addu $4,$0,$0 -> stall=0, all fwd=0, a3_w=0, reg_we_w=0.
// - Drop reset_n during lw/addu stall -> reg_we_w/mem_we_m/stall=0 async; pipe NOP.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decode of the D-stage instruction, E/M/W control bundle pipeline,
// Tuse/Tnew stall generation and forwarding-select generation for a 5-stage MIPS core.
// Interface timing: D-stage outputs are combinational from instr_d; E/M/W outputs
// come from registers that advance every clock. stall=1 holds PC and IF/D and
// loads a bubble into E while M and W keep advancing.
module ctrl_pipe #(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31,
  parameter bit EXT_ISA  = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instr_d,
  output logic              stall,
  output logic [1:0]        npc_sel_d,
  output logic [1:0]        ext_op_d,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic              alu_src_e,
  output logic [1:0]        alu_ctr_e,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              mem_we_m,
  output logic              fwd_rt_m,
  output logic              reg_we_w,
  output logic [1:0]        mem2reg_w,
  output logic [REG_AW-1:0] a3_w
);

  // Control bundle carried through E/M/W. rs/rt hold a source only when the
  // stage that reads the register file value consumes it (0 otherwise), so the
  // forwarding compare never fires for a field the instruction ignores.
  typedef struct packed {
    logic              alu_src;
    logic [1:0]        alu_ctr;
    logic              mem_we;
    logic              reg_we;
    logic [1:0]        mem2reg;
    logic [REG_AW-1:0] a3;
    logic [1:0]        tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } bundle_t;

  bundle_t r_e, r_m, r_w;
  bundle_t w_dec, w_m_next, w_w_next;

  logic [5:0]        w_op, w_fn;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd, w_dest;
  logic w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_addiu;
  logic w_rs_used, w_rt_used;   // source read at all (drives stall)
  logic w_rs_in_d, w_rt_in_d;   // source read by the D-stage comparator / jr
  logic [1:0] w_tuse_rs, w_tuse_rt;
  logic w_stall;
  logic w_unused;

  assign w_op = instr_d[31:26];
  assign w_fn = instr_d[5:0];
  assign w_rs = instr_d[21 +: REG_AW];
  assign w_rt = instr_d[16 +: REG_AW];
  assign w_rd = instr_d[11 +: REG_AW];

  assign w_addu  = (w_op == 6'h00) && (w_fn == 6'h21);
  assign w_subu  = (w_op == 6'h00) && (w_fn == 6'h23);
  assign w_jr    = (w_op == 6'h00) && (w_fn == 6'h08);
  assign w_ori   = (w_op == 6'h0d);
  assign w_lui   = (w_op == 6'h0f);
  assign w_lw    = (w_op == 6'h23);
  assign w_sw    = (w_op == 6'h2b);
  assign w_beq   = (w_op == 6'h04);
  assign w_j     = (w_op == 6'h02);
  assign w_jal   = (w_op == 6'h03);
  assign w_addiu = EXT_ISA && (w_op == 6'h09);

  // A producer in a stage blocks a consumer if its result is not ready in time.
  function automatic logic late_hit(input logic [REG_AW-1:0] src, input bundle_t b,
                                    input logic [1:0] tuse);
    return (src != '0) && b.reg_we && (b.a3 == src) && (b.tnew > tuse);
  endfunction

  // A producer in a stage can supply a consumer once its result exists (Tnew 0).
  function automatic logic ready_hit(input logic [REG_AW-1:0] src, input bundle_t b);
    return (src != '0) && b.reg_we && (b.a3 == src) && (b.tnew == 2'd0);
  endfunction

  // Decode the D-stage instruction into D-side selects, Tuse and the E bundle.
  always_comb begin
    w_dec     = '0;
    w_dest    = '0;
    npc_sel_d = 2'b00;
    ext_op_d  = 2'b00;
    w_rs_used = 1'b0;
    w_rt_used = 1'b0;
    w_rs_in_d = 1'b0;
    w_rt_in_d = 1'b0;
    w_tuse_rs = 2'd0;
    w_tuse_rt = 2'd0;
    if (w_addu || w_subu) begin
      w_dec.alu_ctr = w_subu ? 2'b01 : 2'b00;
      w_dec.reg_we  = 1'b1;
      w_dec.tnew    = 2'd1;
      w_dec.rs      = w_rs;
      w_dec.rt      = w_rt;
      w_dest        = w_rd;
      w_rs_used     = 1'b1;
      w_rt_used     = 1'b1;
      w_tuse_rs     = 2'd1;
      w_tuse_rt     = 2'd1;
    end else if (w_ori || w_lui || w_addiu) begin
      w_dec.alu_src = 1'b1;
      w_dec.alu_ctr = w_ori ? 2'b10 : 2'b00;
      w_dec.reg_we  = 1'b1;
      w_dec.tnew    = 2'd1;
      w_dec.rs      = w_rs;
      w_dest        = w_rt;
      w_rs_used     = 1'b1;
      w_tuse_rs     = 2'd1;
      ext_op_d      = w_ori ? 2'b00 : (w_lui ? 2'b10 : 2'b01);
    end else if (w_lw) begin
      w_dec.alu_src = 1'b1;
      w_dec.reg_we  = 1'b1;
      w_dec.mem2reg = 2'b01;
      w_dec.tnew    = 2'd2;
      w_dec.rs      = w_rs;
      w_dest        = w_rt;
      w_rs_used     = 1'b1;
      w_tuse_rs     = 2'd1;
      ext_op_d      = 2'b01;
    end else if (w_sw) begin
      w_dec.alu_src = 1'b1;
      w_dec.mem_we  = 1'b1;
      w_dec.rs      = w_rs;
      w_dec.rt      = w_rt;
      w_rs_used     = 1'b1;
      w_rt_used     = 1'b1;
      w_tuse_rs     = 2'd1;
      w_tuse_rt     = 2'd2;
      ext_op_d      = 2'b01;
    end else if (w_beq) begin
      npc_sel_d = 2'b01;
      ext_op_d  = 2'b01;
      w_rs_used = 1'b1;
      w_rt_used = 1'b1;
      w_rs_in_d = 1'b1;
      w_rt_in_d = 1'b1;
    end else if (w_j) begin
      npc_sel_d = 2'b10;
    end else if (w_jal) begin
      npc_sel_d     = 2'b10;
      w_dec.reg_we  = 1'b1;
      w_dec.mem2reg = 2'b10;
      w_dest        = REG_AW'(LINK_REG);
    end else if (w_jr) begin
      npc_sel_d = 2'b11;
      w_rs_used = 1'b1;
      w_rs_in_d = 1'b1;
    end
    // Writes to register 0 are dropped here so no later stage ever matches it.
    if (w_dest == '0) w_dec.reg_we = 1'b0;
    w_dec.a3 = w_dec.reg_we ? w_dest : '0;
  end

  // Stall and forwarding selects from the current E/M/W contents.
  always_comb begin
    w_stall = (w_rs_used && (late_hit(w_rs, r_e, w_tuse_rs) || late_hit(w_rs, r_m, w_tuse_rs))) ||
              (w_rt_used && (late_hit(w_rt, r_e, w_tuse_rt) || late_hit(w_rt, r_m, w_tuse_rt)));
    fwd_rs_d = 2'd0;
    fwd_rt_d = 2'd0;
    if (w_rs_in_d) begin
      if (ready_hit(w_rs, r_e))      fwd_rs_d = 2'd1;
      else if (ready_hit(w_rs, r_m)) fwd_rs_d = 2'd2;
    end
    if (w_rt_in_d) begin
      if (ready_hit(w_rt, r_e))      fwd_rt_d = 2'd1;
      else if (ready_hit(w_rt, r_m)) fwd_rt_d = 2'd2;
    end
    fwd_rs_e = ready_hit(r_e.rs, r_m) ? 2'd1 : (ready_hit(r_e.rs, r_w) ? 2'd2 : 2'd0);
    fwd_rt_e = ready_hit(r_e.rt, r_m) ? 2'd1 : (ready_hit(r_e.rt, r_w) ? 2'd2 : 2'd0);
    fwd_rt_m = r_m.mem_we && ready_hit(r_m.rt, r_w);
  end

  // Next M/W bundles: Tnew counts down by one per stage and is zero in W.
  always_comb begin
    w_m_next      = r_e;
    w_m_next.tnew = (r_e.tnew != 2'd0) ? (r_e.tnew - 2'd1) : 2'd0;
    w_w_next      = r_m;
    w_w_next.tnew = 2'd0;
  end

  // E/M/W control registers; a stall loads a bubble into E only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e <= w_stall ? '0 : w_dec;
      r_m <= w_m_next;
      r_w <= w_w_next;
    end
  end

  assign stall     = reset_n && w_stall;
  assign alu_src_e = r_e.alu_src;
  assign alu_ctr_e = r_e.alu_ctr;
  assign mem_we_m  = r_m.mem_we;
  assign reg_we_w  = r_w.reg_we;
  assign mem2reg_w = r_w.mem2reg;
  assign a3_w      = r_w.a3;

  // Shamt and the W-stage fields with no consumer past W.
  assign w_unused = ^{instr_d[10:6], r_w.alu_src, r_w.alu_ctr, r_w.mem_we, r_w.rs, r_w.rt};

endmodule
